// File: rtl/n64_controller_responder.sv
// Controller-side N64 single-wire responder: decodes console command bytes and
// answers poll (0x01) with status_word and info/reset (0x00/0xFF) with ID_WORD.
module n64_controller_responder #(
   parameter int          CLKS_PER_US   = 14,
   parameter logic [23:0] ID_WORD       = 24'h050002,
   parameter int          TURNAROUND_US = 2,
   parameter int          TIMEOUT_US    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        line_in,
   output logic        drive_low,
   input  logic [31:0] status_word,
   output logic [7:0]  cmd,
   output logic        cmd_valid,
   output logic        busy
);

   localparam int US       = CLKS_PER_US;
   localparam int SAMPLE   = 2 * US;
   localparam int ARM_CYC  = 4 * US;
   localparam int TURN_CYC = TURNAROUND_US * US;
   localparam int TO_CYC   = TIMEOUT_US * US;
   localparam int BIT_CYC  = 4 * US;
   localparam int STOP_LO  = 2 * US;
   localparam int STOP_CYC = 3 * US;
   localparam int CW       = $clog2(TO_CYC + ARM_CYC + BIT_CYC + TURN_CYC + 1) + 1;

   typedef enum logic [2:0] {ARM, IDLE, RX, TURN, TX, STOP} state_t;

   state_t         state_q, state_d;
   logic [2:0]     sync_q, sync_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     bit_q, bit_d;
   logic [7:0]     rx_sr_q, rx_sr_d;
   logic [31:0]    tx_sr_q, tx_sr_d;
   logic [5:0]     tx_left_q, tx_left_d;
   logic [7:0]     cmd_q, cmd_d;
   logic           cmd_valid_q, cmd_valid_d;
   logic           busy_q, busy_d;
   logic           drive_low_q, drive_low_d;
   logic           line, fall;

   assign line      = sync_q[1];
   assign fall      = sync_q[2] & ~sync_q[1];
   assign drive_low = drive_low_q;
   assign cmd       = cmd_q;
   assign cmd_valid = cmd_valid_q;
   assign busy      = busy_q;

   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[1:0], line_in};
      cnt_d       = cnt_q + 1'b1;
      bit_d       = bit_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      tx_left_d   = tx_left_q;
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      busy_d      = busy_q;
      case (state_q)
         ARM: begin
            busy_d = 1'b0;
            if (!line) cnt_d = '0;
            else if (cnt_q == CW'(ARM_CYC - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         IDLE: begin
            cnt_d = '0;
            if (fall) begin
               state_d = RX;
               busy_d  = 1'b1;
               bit_d   = '0;
            end
         end
         RX: begin
            if (fall) cnt_d = '0;
            else if (cnt_q >= CW'(TO_CYC)) begin
               state_d = ARM;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q == CW'(SAMPLE)) begin
               if (bit_q < 4'd8) begin
                  rx_sr_d = {rx_sr_q[6:0], line};
                  bit_d   = bit_q + 4'd1;
               end else if (!line) begin
                  state_d = ARM;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end else begin
                  // Stop bit read high: the rising edge is already behind us.
                  cmd_d       = rx_sr_q;
                  cmd_valid_d = 1'b1;
                  cnt_d       = '0;
                  if (rx_sr_q == 8'h01) begin
                     state_d   = TURN;
                     tx_sr_d   = status_word;
                     tx_left_d = 6'd32;
                  end else if (rx_sr_q == 8'h00 || rx_sr_q == 8'hFF) begin
                     state_d   = TURN;
                     tx_sr_d   = {ID_WORD, 8'h00};
                     tx_left_d = 6'd24;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end
         end
         TURN: begin
            if (cnt_q == CW'(TURN_CYC - 1)) begin
               state_d = TX;
               cnt_d   = '0;
            end
         end
         TX: begin
            if (cnt_q == CW'(BIT_CYC - 1)) begin
               cnt_d     = '0;
               tx_sr_d   = {tx_sr_q[30:0], 1'b0};
               tx_left_d = tx_left_q - 6'd1;
               if (tx_left_q == 6'd1) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == CW'(STOP_CYC - 1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ARM;
            cnt_d   = '0;
         end
      endcase
      // Drive is a function of the next state so the pad sees a clean registered edge.
      drive_low_d = ((state_d == TX) && (cnt_d < (tx_sr_d[31] ? CW'(US) : CW'(3 * US)))) ||
                    ((state_d == STOP) && (cnt_d < CW'(STOP_LO)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARM;
         sync_q      <= 3'b111;
         cnt_q       <= '0;
         bit_q       <= '0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         tx_left_q   <= '0;
         cmd_q       <= 8'h00;
         cmd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         drive_low_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         tx_left_q   <= tx_left_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         busy_q      <= busy_d;
         drive_low_q <= drive_low_d;
      end
   end

endmodule

// File: doc/n64_controller_responder.md
Name: n64_controller_responder

Overview:
- Controller-side end of the N64 single-wire protocol. It listens on the open-drain data line for console commands and replies in N64 pulse-width encoding.
- Answers 0x01 (poll) with a 32-bit status word, and 0x00 / 0xFF (info/reset) with a 24-bit ID.
- Used to emulate a controller so the team's console-side receiver path can be exercised in hardware and on the bench.

Parameters:
- CLKS_PER_US, 14, clk cycles per microsecond (OSCH at 14.00 MHz).
- ID_WORD, 24'h050002, reply to commands 0x00 and 0xFF.
- TURNAROUND_US, 2, line-high time after the console stop bit before the reply starts.
- TIMEOUT_US, 16, maximum low or high time inside a frame before abort.

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- line_in  in  1  raw N64 data line sampled from the pad (asynchronous).
- drive_low  out  1  1 = pull the open-drain line low; 0 = release.
- status_word  in  32  {A,B,Z,Start,Up,Down,Left,Right,2'b0,L,R,C-Up,C-Down,C-Left,C-Right,stick_x[7:0],stick_y[7:0]}, MSB sent first.
- cmd  out  8  last fully received command byte.
- cmd_valid  out  1  one-cycle pulse when cmd updates (stop bit seen).
- busy  out  1  high from the first command falling edge until the reply stop bit completes.

Behaviour:
- Reset (async, Reset=0):
  - drive_low=0, cmd=8'h00, cmd_valid=0, busy=0, state=ARM.
  - Reset mid-reply releases the line immediately.
- Input path:
  - line_in passes a 2-flop synchronizer, then a third flop for falling-edge detect.
  - Edge latency is 3 clk cycles; all timing is measured from the detected edge.
- Bit decode: each console bit is sampled at 2 us (2*CLKS_PER_US cycles) after its falling edge. Low = 0, high = 1.
- States:
  - ARM: wait for line high for 4 us continuously, then go to IDLE. Entered after reset or abort.
  - IDLE: on falling edge go to RX (bit counter=0, busy=1).
  - RX:
    - Shift the decoded bit into the command register MSB-first.
    - After 8 bits, the next falling edge is the stop bit; it must read high at the 2 us sample.
    - On the stop bit rising edge: cmd <= shift register and pulse cmd_valid.
    - If cmd is 0x01, 0x00 or 0xFF, go to TURN. Otherwise go to IDLE with busy=0 and no reply.
  - TURN:
    - Latch the reply source when entering TURN:
      - status_word for 0x01, 32 bits;
      - ID_WORD for 0x00/0xFF, 24 bits.
    - Wait TURNAROUND_US with line released, then go to TX.
  - TX:
    - Per bit, MSB first: bit 0 = 3 us low, 1 us high; bit 1 = 1 us low, 3 us high.
    - line_in is ignored while in TX.
    - After the last bit, go to STOP.
  - STOP: 2 us low, then release. After 1 us released, go to IDLE with busy=0.
- Aborts:
  - In RX, line low or high for more than TIMEOUT_US: go to ARM, busy=0, no cmd_valid.
  - A 0 sampled in the stop slot: go to ARM, busy=0, no cmd_valid.
- status_word changes after the TURN latch do not affect the reply in flight.
- Frame length: a 0x01 reply is exactly 32*4 + 2 us of driven activity. drive_low edges fall on exact cycle counts (multiples of CLKS_PER_US).
- A command arriving back-to-back: a falling edge seen in IDLE within the same cycle busy drops is accepted.

Test Plan:
- Reset asserted, line high, then released: after 4 us → IDLE. drive_low=0, busy=0, cmd=0x00.
- Console sends 0x01 + stop, status_word=0x8000_7F81 → cmd_valid pulses once with cmd=0x01. After 2 us, the reply decodes to 0x80007F81 (bit 0 = 42 low / 14 high cycles, bit 1 = 14 / 42), then 28 low cycles for stop, then busy=0.
- Console sends 0xFF → 24-bit reply 0x050002. Console sends 0x00 → same reply.
- Console sends 0x02 → cmd_valid with cmd=0x02; drive_low stays 0 and busy falls after the stop bit.
- Line held low for 20 us mid-command → abort to ARM, busy=0, no cmd_valid. A following valid 0x01 after 4 us high is answered normally.
- Reset pulsed low mid-reply (bit 10 of 32) → drive_low=0 in the same cycle. After release, no further reply; a new poll is answered.
